room_loader: RTL
================

Name: room_loader

Overview:
Writer side of the collision tilemap that movement collision (is_solid) reads. On a room change, it walks the 16x16 tiles of the selected room in the 128x64 map ROM and looks up each tile's flag byte. It writes one solid bit per tile into the solid-map RAM. It also services single-tile clear requests (breakable/fall floors) while idle.

Parameters:
ROOM_W, 16, tiles per room edge (room = ROOM_W*ROOM_W cells)
MAP_COLS, 128, tiles per map ROM row
ROOMS_PER_ROW, 8, rooms across the map (4 rows of rooms, 32 rooms)
SOLID_BIT, 0, flag-byte bit that marks a tile solid

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  load request, sampled only in IDLE
room_i  in  5  room index 0..31, sampled with start_i
busy_o  out  1  high from accepted start until done_o cycle inclusive
done_o  out  1  one-cycle pulse, load complete
room_o  out  5  room latched at last accepted start
map_addr_o  out  13  map ROM address; data returns 1 cycle later
map_data_i  in  8  tile id
flag_addr_o  out  8  flag ROM address; data returns 1 cycle later
flag_data_i  in  8  flag byte
sol_we_o  out  1  solid-map write enable
sol_addr_o  out  8  cell index, y*16+x
sol_data_o  out  1  solid bit
clr_valid_i  in  1  tile clear request
clr_ready_o  out  1  high in IDLE only
clr_x_i  in  4  cell x to clear
clr_y_i  in  4  cell y to clear

Behaviour:
- Reset values: busy_o=0, done_o=0, room_o=0, map_addr_o=0, flag_addr_o=0, sol_we_o=0, sol_addr_o=0, sol_data_o=0. State is IDLE, so clr_ready_o=1.
- Reset mid-load aborts immediately. Solid map is left partially written, with no rollback.
- FSM: IDLE -> LOAD on start_i. LOAD holds an 8-bit index k from 0 to 255, then goes to DRAIN. DRAIN lasts 2 cycles, then DONE. DONE lasts 1 cycle (done_o=1), then IDLE.
- start_i outside IDLE is ignored.
- Address for index k in room r: map_addr = ((r>>3)*16 + k[7:4])*128 + (r&7)*16 + k[3:0].
- Pipeline:
  - Cycle c: map_addr_o(k).
  - c+1: flag_addr_o = map_data_i, combinational, registered index delayed.
  - c+2: sol_we_o=1, sol_addr_o=k, sol_data_o=flag_data_i[SOLID_BIT].
  - Writes occur in strictly increasing k order, one per cycle. Exactly 256 writes per load.
- done_o is high in the 259th cycle after the start-accept edge. LOAD is cycles 1-256, DRAIN is 257-258, DONE is 259.
- Clear handshake: accepted on clr_valid_i & clr_ready_o. The next cycle drives sol_we_o=1, sol_addr_o={clr_y_i,clr_x_i}, sol_data_o=0.
- Clear and start in the same IDLE cycle: both are accepted. The clear write lands in LOAD cycle 1, and load writes begin in cycle 3, so there is no port conflict.
- sol_we_o is 0 in all other cycles.

Optional Feature:
ROOM_LOADER_FAKE_WALL_EN.
- Defined: when room_o==0, cells (x,y) = (4,1), (4,2), (5,1), (5,2) are written solid=1 regardless of flag byte. This is the berry-block wall in room 100m.
- Undefined: solid bit comes from flags only.

Decomposition:
- utils package: ROOM_W, MAP_COLS, ROOMS_PER_ROW, SOLID_BIT, typedef room_t (5b), typedef cell_idx_t (8b), loader state enum.
- One combinational sub-module, room_addr, maps (room_t, cell_idx_t) to the 13-bit map address.

Test Plan:
- Room 0 load, map ROM tile=idx, flag ROM bit0 = tile odd -> 256 writes, sol_data_o alternating 0,1. First write 3 cycles after accept. done_o in cycle 259, single pulse.
- Room 9 load -> map_addr_o=2064 for k=0, 3999 for k=255. Room 31, k=255 -> 8191.
- start_i held high throughout load -> no restart. busy_o continuous, exactly one done_o per accept.
- clr_valid_i with x=5, y=3 in IDLE -> next cycle write addr 53, data 0. clr_valid_i during LOAD -> clr_ready_o=0, no extra write.
- rst_ni low at k=100 -> all outputs at reset values immediately (async). A new start after release performs a full 256-write load.
- With ROOM_LOADER_FAKE_WALL_EN and all flags 0, room 0 -> writes to addr 20, 36, 21, 37 carry 1, all others 0. Room 1 -> all 0.

Source files
------------

// File: rtl/room_loader_pkg.sv
// room_loader_pkg: shared geometry constants, types and FSM states for the room loader.
// Contents:
//   ROOM_W, MAP_COLS, ROOMS_PER_ROW, SOLID_BIT - map geometry and flag-byte layout
//   room_t, cell_idx_t, map_addr_t             - room index, cell index, map ROM address
//   state_t                                    - loader FSM states
package room_loader_pkg;
    localparam int ROOM_W        = 16;
    localparam int MAP_COLS      = 128;
    localparam int ROOMS_PER_ROW = 8;
    localparam int SOLID_BIT     = 0;
    localparam int ROOM_CELLS    = ROOM_W * ROOM_W;

    typedef logic [4:0]  room_t;
    typedef logic [7:0]  cell_idx_t;
    typedef logic [12:0] map_addr_t;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN, ST_DONE} state_t;

    localparam cell_idx_t LAST_CELL  = cell_idx_t'(ROOM_CELLS - 1);
    // DRAIN reuses the cell counter, which restarts at 0, so two cycles end at 1
    localparam cell_idx_t DRAIN_LAST = 8'd1;
endpackage

// File: rtl/room_loader_room_addr.sv
// room_addr: maps a room index and a cell index inside that room to a map ROM address.
// Ports:
//   i_room - room index 0..31
//   i_cell - cell index y*16+x inside the room
//   o_addr - 13-bit map ROM address
module room_addr
    import room_loader_pkg::*;
(
    input  logic [4:0]  i_room,
    input  logic [7:0]  i_cell,
    output logic [12:0] o_addr
);
    // map row = room row * ROOM_W + cell y; map column = room column * ROOM_W + cell x
    assign o_addr = (map_addr_t'(i_room / room_t'(ROOMS_PER_ROW)) * map_addr_t'(ROOM_W)
                   + map_addr_t'(i_cell / cell_idx_t'(ROOM_W))) * map_addr_t'(MAP_COLS)
                   + map_addr_t'(i_room % room_t'(ROOMS_PER_ROW)) * map_addr_t'(ROOM_W)
                   + map_addr_t'(i_cell % cell_idx_t'(ROOM_W));
endmodule

// File: rtl/room_loader.sv
// room_loader: walks a room's tiles through map and flag ROMs and writes one solid bit per cell.
// Optional feature macro: ROOM_LOADER_FAKE_WALL_EN forces the berry-block wall cells of room 0 solid.
// Ports:
//   clk_i, rst_ni              - clock, asynchronous active-low reset
//   start_i, room_i            - load request and room index, sampled in IDLE
//   busy_o, done_o, room_o     - load in progress, completion pulse, last accepted room
//   map_addr_o, map_data_i     - map ROM port (1-cycle read latency)
//   flag_addr_o, flag_data_i   - flag ROM port (1-cycle read latency)
//   sol_we_o, sol_addr_o, sol_data_o - solid-map RAM write port
//   clr_valid_i, clr_ready_o, clr_x_i, clr_y_i - single-cell clear handshake
module room_loader
    import room_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [4:0]  room_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [4:0]  room_o,
    output logic [12:0] map_addr_o,
    input  logic [7:0]  map_data_i,
    output logic [7:0]  flag_addr_o,
    input  logic [7:0]  flag_data_i,
    output logic        sol_we_o,
    output logic [7:0]  sol_addr_o,
    output logic        sol_data_o,
    input  logic        clr_valid_i,
    output logic        clr_ready_o,
    input  logic [3:0]  clr_x_i,
    input  logic [3:0]  clr_y_i
);
    state_t    r_state;
    state_t    w_state_nxt;
    cell_idx_t r_k;
    cell_idx_t w_k_nxt;
    room_t     r_room;
    logic      r_v1;
    logic      r_v2;
    cell_idx_t r_k1;
    cell_idx_t r_k2;
    logic      r_clr;
    cell_idx_t r_clr_addr;
    logic      w_start_acc;
    logic      w_clr_acc;
    logic      w_fake;
    logic      w_flag_unused;

    room_addr u_room_addr (
        .i_room (r_room),
        .i_cell (r_k),
        .o_addr (map_addr_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = '0;
        case (r_state)
            ST_IDLE:  w_state_nxt = start_i ? ST_LOAD : ST_IDLE;
            ST_LOAD: begin
                w_state_nxt = (r_k == LAST_CELL) ? ST_DRAIN : ST_LOAD;
                w_k_nxt     = r_k + 8'd1;
            end
            ST_DRAIN: begin
                w_state_nxt = (r_k == DRAIN_LAST) ? ST_DONE : ST_DRAIN;
                w_k_nxt     = r_k + 8'd1;
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        busy_o      = r_state != ST_IDLE;
        done_o      = r_state == ST_DONE;
        clr_ready_o = r_state == ST_IDLE;
    end

    assign w_start_acc = (r_state == ST_IDLE) && start_i;
    assign w_clr_acc   = clr_valid_i && clr_ready_o;

    // r_v1/r_k1 track the cell whose tile id is on map_data_i, r_v2/r_k2 the one whose flags are on flag_data_i
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_room     <= '0;
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
            r_k1       <= '0;
            r_k2       <= '0;
            r_clr      <= 1'b0;
            r_clr_addr <= '0;
        end else begin
            r_room     <= w_start_acc ? room_i : r_room;
            r_v1       <= r_state == ST_LOAD;
            r_v2       <= r_v1;
            r_k1       <= r_k;
            r_k2       <= r_k1;
            r_clr      <= w_clr_acc;
            r_clr_addr <= w_clr_acc ? {clr_y_i, clr_x_i} : r_clr_addr;
        end
    end

`ifdef ROOM_LOADER_FAKE_WALL_EN
    // berry-block wall in room 0: cells (4,1) (5,1) (4,2) (5,2)
    assign w_fake = (r_room == '0) && (r_k2 inside {8'd20, 8'd21, 8'd36, 8'd37});
`else
    assign w_fake = 1'b0;
`endif

    assign w_flag_unused = ^flag_data_i;

    assign room_o      = r_room;
    assign flag_addr_o = r_v1 ? map_data_i : '0;
    // clears only land in IDLE or LOAD cycle 1, load writes start at cycle 3, so they never collide
    assign sol_we_o    = r_clr || r_v2;
    assign sol_addr_o  = r_clr ? r_clr_addr : (r_v2 ? r_k2 : '0);
    assign sol_data_o  = !r_clr && r_v2 && (flag_data_i[SOLID_BIT] || w_fake);
endmodule
